// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI-to-SRAM slave.
package axi_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    RD_VALID,
    WR_DATA,
    WR_RESP
  } axiStateT;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_SIZE_WORD   = 2'd2;

  function automatic logic [31:0] incrAddr(input logic [31:0] addr, input logic [1:0] size);
    return addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/axi_sram_addr_gen.sv
// Burst address/beat tracker for axi_sram_slave.
// With AXI_SRAM_RANGE_CHECK_EN defined it also flags beats beyond the SRAM capacity.
module axi_sram_addr_gen
  import axi_sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] loadAddr,
  input  logic [7:0]  loadLen,
  input  logic [1:0]  loadSize,
  input  logic        advance,
  output logic [31:0] curAddr,
  output logic        lastBeat,
  output logic        outOfRange
);

  logic [7:0] beat;
  logic [7:0] len;
  logic [1:0] size;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      curAddr <= 32'h0;
      beat    <= 8'h0;
      len     <= 8'h0;
      size    <= 2'h0;
    end else if (load) begin
      curAddr <= loadAddr;
      beat    <= 8'h0;
      len     <= loadLen;
      size    <= loadSize;
    end else if (advance) begin
      curAddr <= incrAddr(curAddr, size);
      beat    <= beat + 8'd1;
    end
  end

  assign lastBeat = (beat == len);

`ifdef AXI_SRAM_RANGE_CHECK_EN
  assign outOfRange = |curAddr[31:DEPTH_LOG2+2];
`else
  // Without the check, high address bits simply alias onto the SRAM.
  assign outOfRange = 1'b0;
`endif

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 INCR-burst slave in front of a single-port synchronous SRAM, one transaction at a time.
// Optional range checking is enabled by defining AXI_SRAM_RANGE_CHECK_EN.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_arAddr,
  input  logic [7:0]  io_arLen,
  input  logic [1:0]  io_arSize,
  input  logic        io_arValid,
  output logic        io_arReady,
  output logic [31:0] io_rData,
  output logic [1:0]  io_rResp,
  output logic        io_rLast,
  output logic        io_rValid,
  input  logic        io_rReady,
  input  logic [31:0] io_awAddr,
  input  logic [7:0]  io_awLen,
  input  logic [1:0]  io_awSize,
  input  logic        io_awValid,
  output logic        io_awReady,
  input  logic [31:0] io_wData,
  input  logic [3:0]  io_wStrb,
  input  logic        io_wLast,
  input  logic        io_wValid,
  output logic        io_wReady,
  output logic [1:0]  io_bResp,
  output logic        io_bValid,
  input  logic        io_bReady,
  output logic        io_sram_en,
  output logic [3:0]  io_sram_wen,
  output logic [31:0] io_sram_addr,
  output logic [31:0] io_sram_wdata,
  input  logic [31:0] io_sram_rdata
);

  axiStateT    state, nextState;
  logic        lastRd;
  logic        errSeen;
  logic        arGrant;
  logic        load;
  logic        advance;
  logic [31:0] loadAddr;
  logic [7:0]  loadLen;
  logic [1:0]  loadSize;
  logic [31:0] curAddr;
  logic        lastBeat;
  logic        outOfRange;

  // Round-robin: a read wins a collision unless the previous grant was also a read.
  assign arGrant  = io_arValid && (!io_awValid || !lastRd);
  assign load     = io_arReady || io_awReady;
  assign loadAddr = io_arReady ? io_arAddr : io_awAddr;
  assign loadLen  = io_arReady ? io_arLen  : io_awLen;
  assign loadSize = io_arReady ? io_arSize : io_awSize;

  axi_sram_addr_gen #(.DEPTH_LOG2(DEPTH_LOG2)) addrGen (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .loadAddr   (loadAddr),
    .loadLen    (loadLen),
    .loadSize   (loadSize),
    .advance    (advance),
    .curAddr    (curAddr),
    .lastBeat   (lastBeat),
    .outOfRange (outOfRange)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lastRd   <= 1'b0;
      errSeen  <= 1'b0;
      io_rData <= 32'h0;
      io_rResp <= AXI_RESP_OKAY;
    end else begin
      state <= nextState;
      if (io_arReady) lastRd <= 1'b1;
      else if (io_awReady) lastRd <= 1'b0;
      if (io_awReady) errSeen <= 1'b0;
      else if (state == WR_DATA && io_wValid && outOfRange) errSeen <= 1'b1;
      if (state == RD_CAP) begin
        io_rData <= outOfRange ? 32'h0 : io_sram_rdata;
        io_rResp <= outOfRange ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  // Ready gating on reset keeps every output low while reset is held, even in IDLE.
  always_comb begin
    nextState     = state;
    advance       = 1'b0;
    io_arReady    = 1'b0;
    io_awReady    = 1'b0;
    io_rValid     = 1'b0;
    io_rLast      = 1'b0;
    io_wReady     = 1'b0;
    io_bValid     = 1'b0;
    io_bResp      = AXI_RESP_OKAY;
    io_sram_en    = 1'b0;
    io_sram_wen   = 4'h0;
    io_sram_addr  = 32'h0;
    io_sram_wdata = 32'h0;
    case (state)
      IDLE: begin
        io_arReady = reset && arGrant;
        io_awReady = reset && io_awValid && !arGrant;
        if (io_arReady) nextState = RD_REQ;
        else if (io_awReady) nextState = WR_DATA;
      end
      RD_REQ: begin
        io_sram_en   = !outOfRange;
        io_sram_addr = curAddr;
        nextState    = RD_CAP;
      end
      RD_CAP: nextState = RD_VALID;
      RD_VALID: begin
        io_rValid = 1'b1;
        io_rLast  = lastBeat;
        if (io_rReady) begin
          nextState = lastBeat ? IDLE : RD_REQ;
          advance   = !lastBeat;
        end
      end
      WR_DATA: begin
        io_wReady = 1'b1;
        if (io_wValid) begin
          io_sram_en    = !outOfRange;
          io_sram_wen   = outOfRange ? 4'h0 : io_wStrb;
          io_sram_addr  = curAddr;
          io_sram_wdata = io_wData;
          advance       = 1'b1;
          if (io_wLast) nextState = WR_RESP;
        end
      end
      WR_RESP: begin
        io_bValid = 1'b1;
        io_bResp  = errSeen ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (io_bReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave with an SRAM model and read/write scoreboards.
module tb_axi_sram_slave;
  import axi_sram_pkg::*;

  localparam int DEPTH_LOG2 = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] io_arAddr = '0;
  logic [7:0]  io_arLen = '0;
  logic [1:0]  io_arSize = '0;
  logic        io_arValid = 1'b0;
  logic        io_arReady;
  logic [31:0] io_rData;
  logic [1:0]  io_rResp;
  logic        io_rLast;
  logic        io_rValid;
  logic        io_rReady = 1'b0;
  logic [31:0] io_awAddr = '0;
  logic [7:0]  io_awLen = '0;
  logic [1:0]  io_awSize = '0;
  logic        io_awValid = 1'b0;
  logic        io_awReady;
  logic [31:0] io_wData = '0;
  logic [3:0]  io_wStrb = '0;
  logic        io_wLast = 1'b0;
  logic        io_wValid = 1'b0;
  logic        io_wReady;
  logic [1:0]  io_bResp;
  logic        io_bValid;
  logic        io_bReady = 1'b0;
  logic        io_sram_en;
  logic [3:0]  io_sram_wen;
  logic [31:0] io_sram_addr;
  logic [31:0] io_sram_wdata;
  logic [31:0] io_sram_rdata;

  axi_sram_slave #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clock(clock), .reset(reset),
    .io_arAddr(io_arAddr), .io_arLen(io_arLen), .io_arSize(io_arSize),
    .io_arValid(io_arValid), .io_arReady(io_arReady),
    .io_rData(io_rData), .io_rResp(io_rResp), .io_rLast(io_rLast),
    .io_rValid(io_rValid), .io_rReady(io_rReady),
    .io_awAddr(io_awAddr), .io_awLen(io_awLen), .io_awSize(io_awSize),
    .io_awValid(io_awValid), .io_awReady(io_awReady),
    .io_wData(io_wData), .io_wStrb(io_wStrb), .io_wLast(io_wLast),
    .io_wValid(io_wValid), .io_wReady(io_wReady),
    .io_bResp(io_bResp), .io_bValid(io_bValid), .io_bReady(io_bReady),
    .io_sram_en(io_sram_en), .io_sram_wen(io_sram_wen), .io_sram_addr(io_sram_addr),
    .io_sram_wdata(io_sram_wdata), .io_sram_rdata(io_sram_rdata)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] data;
  } wrBeatT;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rdBeatT;

  int     testsRun = 0;
  int     testsFailed = 0;
  int     readEnCount = 0;
  wrBeatT wrExpQ[$];
  wrBeatT wrObsQ[$];
  rdBeatT rdExpQ[$];
  rdBeatT rdObsQ[$];

  logic [31:0] sramMem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] expMem  [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] sramIdx;
  assign sramIdx = io_sram_addr[DEPTH_LOG2+1:2];

  // Synchronous SRAM: byte-masked write, read data one cycle after a read request.
  always @(posedge clock) begin
    if (io_sram_en) begin
      if (io_sram_wen == 4'h0) io_sram_rdata <= sramMem[sramIdx];
      else for (int b = 0; b < 4; b++)
        if (io_sram_wen[b]) sramMem[sramIdx][8*b +: 8] = io_sram_wdata[8*b +: 8];
    end
  end

  always @(negedge clock) begin
    if (io_sram_en && io_sram_wen != 4'h0)
      wrObsQ.push_back('{addr: io_sram_addr, wen: io_sram_wen, data: io_sram_wdata});
    if (io_sram_en && io_sram_wen == 4'h0) readEnCount++;
    if (io_rValid && io_rReady)
      rdObsQ.push_back('{data: io_rData, resp: io_rResp, last: io_rLast});
  end

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = oldW;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = newW[8*b +: 8];
    return res;
  endfunction

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    stepCycle();
    stepCycle();
    reset = 1'b1;
    stepCycle();
  endtask

  task automatic issueAr(input logic [31:0] addr, input logic [7:0] len, output bit ok);
    io_arAddr = addr; io_arLen = len; io_arSize = AXI_SIZE_WORD; io_arValid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clock);
      ok = io_arReady;
      stepCycle();
    end
    io_arValid = 1'b0;
  endtask

  task automatic issueAw(input logic [31:0] addr, input logic [7:0] len, output bit ok);
    io_awAddr = addr; io_awLen = len; io_awSize = AXI_SIZE_WORD; io_awValid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clock);
      ok = io_awReady;
      stepCycle();
    end
    io_awValid = 1'b0;
  endtask

  task automatic sendBeat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                          output bit ok);
    io_wData = data; io_wStrb = strb; io_wLast = last; io_wValid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clock);
      ok = io_wReady;
      stepCycle();
    end
    io_wValid = 1'b0; io_wLast = 1'b0;
  endtask

  task automatic finishRead(output bit ok);
    io_rReady = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clock);
      ok = io_rValid && io_rLast;
      stepCycle();
    end
  endtask

  task automatic finishWrite(output bit ok);
    io_bReady = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clock);
      ok = io_bValid;
      stepCycle();
    end
    io_bReady = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    reset = 1'b0;
    io_arValid = 1'b1; io_awValid = 1'b1; io_wValid = 1'b1; io_wLast = 1'b1;
    io_rReady = 1'b1; io_bReady = 1'b1;
    #3;
    testsRun++;
    if ({io_arReady, io_awReady, io_wReady, io_rValid, io_rLast, io_bValid, io_sram_en} !== 7'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_handshake: got %b expected 0", {io_arReady, io_awReady, io_wReady,
               io_rValid, io_rLast, io_bValid, io_sram_en});
    end
    testsRun++;
    if ({io_rData, io_rResp, io_bResp} !== 36'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_rdata_resp: got %h expected 0", {io_rData, io_rResp, io_bResp});
    end
    testsRun++;
    if ({io_sram_wen, io_sram_addr, io_sram_wdata} !== 68'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_sram: got %h expected 0", {io_sram_wen, io_sram_addr, io_sram_wdata});
    end
    io_arValid = 1'b0; io_awValid = 1'b0; io_wValid = 1'b0; io_wLast = 1'b0;
    io_rReady = 1'b0; io_bReady = 1'b0;
    stepCycle();
    stepCycle();
    reset = 1'b1;
    stepCycle();
  endtask

  task automatic test_single_read();
    rdObsQ.delete(); rdExpQ.delete();
    io_rReady = 1'b1;
    rdExpQ.push_back('{data: expMem[4], resp: AXI_RESP_OKAY, last: 1'b1});
    io_arAddr = 32'h10; io_arLen = 8'd0; io_arSize = AXI_SIZE_WORD; io_arValid = 1'b1;
    @(negedge clock);
    testsRun++;
    if (io_arReady !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL single_arReady: got %b expected 1", io_arReady);
    end
    stepCycle();
    io_arValid = 1'b0;
    @(negedge clock);
    testsRun++;
    if ({io_sram_en, io_sram_wen, io_sram_addr} !== {1'b1, 4'h0, 32'h10}) begin
      testsFailed++;
      $display("[TB] FAIL single_sram_req: got en=%b wen=%h addr=%h expected en=1 wen=0 addr=00000010",
               io_sram_en, io_sram_wen, io_sram_addr);
    end
    stepCycle();
    @(negedge clock);
    testsRun++;
    if ({io_rValid, io_sram_en} !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL single_cap_cycle: got rValid/en=%b expected 00", {io_rValid, io_sram_en});
    end
    stepCycle();
    @(negedge clock);
    testsRun++;
    if ({io_rValid, io_rLast, io_rResp, io_rData} !== {1'b1, 1'b1, AXI_RESP_OKAY, expMem[4]}) begin
      testsFailed++;
      $display("[TB] FAIL single_rbeat: got v=%b l=%b resp=%b data=%h expected v=1 l=1 resp=00 data=%h",
               io_rValid, io_rLast, io_rResp, io_rData, expMem[4]);
    end
    stepCycle();
    testsRun++;
    if (rdObsQ.size() != 1 || rdObsQ[0] !== rdExpQ[0]) begin
      testsFailed++; $display("[TB] FAIL single_scoreboard: got %0d beats expected 1 matching", rdObsQ.size());
    end
    io_rReady = 1'b0;
  endtask

  task automatic test_write_burst();
    bit ok, allOk;
    wrBeatT expW, obsW;
    wrObsQ.delete(); wrExpQ.delete();
    allOk = 1'b1;
    issueAw(32'h20, 8'd3, ok);
    allOk &= ok;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] strb;
      strb = (k == 0) ? 4'hF : 4'h1;
      wrExpQ.push_back('{addr: 32'h20 + 32'(4*k), wen: strb, data: 32'hD0C0_B0A0 + 32'(k)});
      expMem[8+k] = mergeBytes(expMem[8+k], 32'hD0C0_B0A0 + 32'(k), strb);
      sendBeat(32'hD0C0_B0A0 + 32'(k), strb, k == 3, ok);
      allOk &= ok;
    end
    @(negedge clock);
    testsRun++;
    if ({io_bValid, io_bResp} !== {1'b1, AXI_RESP_OKAY}) begin
      testsFailed++; $display("[TB] FAIL write_bresp: got bValid=%b bResp=%b expected 1/00", io_bValid, io_bResp);
    end
    stepCycle();
    finishWrite(ok);
    allOk &= ok;
    testsRun++;
    if (!allOk) begin
      testsFailed++; $display("[TB] FAIL write_handshakes: got timeout expected all handshakes");
    end
    testsRun++;
    if (wrObsQ.size() != wrExpQ.size()) begin
      testsFailed++; $display("[TB] FAIL write_count: got %0d expected %0d", wrObsQ.size(), wrExpQ.size());
    end
    while (wrExpQ.size() > 0 && wrObsQ.size() > 0) begin
      expW = wrExpQ.pop_front();
      obsW = wrObsQ.pop_front();
      testsRun++;
      if (obsW !== expW) begin
        testsFailed++; $display("[TB] FAIL write_beat: got %h expected %h", obsW, expW);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, allOk;
    rdBeatT expR, obsR;
    rdObsQ.delete(); rdExpQ.delete();
    allOk = 1'b1;
    for (int k = 0; k < 4; k++)
      rdExpQ.push_back('{data: expMem[8+k], resp: AXI_RESP_OKAY, last: k == 3});
    for (int k = 0; k < 2; k++)
      rdExpQ.push_back('{data: expMem[64+k], resp: AXI_RESP_OKAY, last: k == 1});
    issueAr(32'h20, 8'd3, ok);  allOk &= ok;
    finishRead(ok);             allOk &= ok;
    issueAr(32'h100, 8'd1, ok); allOk &= ok;
    finishRead(ok);             allOk &= ok;
    io_rReady = 1'b0;
    testsRun++;
    if (!allOk || rdObsQ.size() != rdExpQ.size()) begin
      testsFailed++;
      $display("[TB] FAIL b2b_count: got %0d beats ok=%b expected %0d", rdObsQ.size(), allOk, rdExpQ.size());
    end
    while (rdExpQ.size() > 0 && rdObsQ.size() > 0) begin
      expR = rdExpQ.pop_front();
      obsR = rdObsQ.pop_front();
      testsRun++;
      if (obsR !== expR) begin
        testsFailed++; $display("[TB] FAIL b2b_beat: got %h expected %h", obsR, expR);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, seen, stable;
    int enSnap;
    logic [31:0] held;
    rdObsQ.delete();
    io_rReady = 1'b0;
    issueAr(32'h40, 8'd1, ok);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      seen = io_rValid;
      if (!seen) stepCycle();
    end
    held = io_rData;
    enSnap = readEnCount;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      stepCycle();
      @(negedge clock);
      stable &= io_rValid && (io_rData === held) && !io_rLast && (io_rResp === AXI_RESP_OKAY);
    end
    testsRun++;
    if (!(ok && seen) || held !== expMem[16]) begin
      testsFailed++; $display("[TB] FAIL stall_data: got %h expected %h", held, expMem[16]);
    end
    testsRun++;
    if (!stable) begin
      testsFailed++; $display("[TB] FAIL stall_stable: got changing beat expected held beat");
    end
    testsRun++;
    if (readEnCount != enSnap) begin
      testsFailed++; $display("[TB] FAIL stall_no_sram: got %0d reads expected %0d", readEnCount, enSnap);
    end
    stepCycle();
    finishRead(ok);
    io_rReady = 1'b0;
    testsRun++;
    if (!ok || rdObsQ.size() != 2 || rdObsQ[1] !== {expMem[17], AXI_RESP_OKAY, 1'b1}) begin
      testsFailed++; $display("[TB] FAIL stall_tail: got %0d beats expected 2 ending %h", rdObsQ.size(), expMem[17]);
    end
  endtask

  task automatic test_collision();
    bit ok;
    doReset();
    rdObsQ.delete(); wrObsQ.delete();
    io_arAddr = 32'h50; io_arLen = 8'd0; io_arSize = AXI_SIZE_WORD; io_arValid = 1'b1;
    io_awAddr = 32'h60; io_awLen = 8'd0; io_awSize = AXI_SIZE_WORD; io_awValid = 1'b1;
    @(negedge clock);
    testsRun++;
    if ({io_arReady, io_awReady} !== 2'b10) begin
      testsFailed++; $display("[TB] FAIL collide_first: got ar/aw=%b expected 10", {io_arReady, io_awReady});
    end
    stepCycle();
    io_arValid = 1'b0;
    finishRead(ok);
    io_rReady = 1'b0;
    io_arAddr = 32'h54; io_arValid = 1'b1;
    @(negedge clock);
    testsRun++;
    if ({io_arReady, io_awReady} !== 2'b01 || !ok) begin
      testsFailed++; $display("[TB] FAIL collide_second: got ar/aw=%b expected 01", {io_arReady, io_awReady});
    end
    stepCycle();
    io_awValid = 1'b0;
    expMem[24] = 32'h6060_6060;
    sendBeat(32'h6060_6060, 4'hF, 1'b1, ok);
    finishWrite(ok);
    io_awValid = 1'b1;
    @(negedge clock);
    testsRun++;
    if ({io_arReady, io_awReady} !== 2'b10) begin
      testsFailed++; $display("[TB] FAIL collide_third: got ar/aw=%b expected 10", {io_arReady, io_awReady});
    end
    stepCycle();
    io_arValid = 1'b0; io_awValid = 1'b0;
    finishRead(ok);
    io_rReady = 1'b0;
    testsRun++;
    if (rdObsQ.size() != 2 || rdObsQ[0].data !== expMem[20] || rdObsQ[1].data !== expMem[21] ||
        wrObsQ.size() != 1 || wrObsQ[0] !== {32'h60, 4'hF, 32'h6060_6060}) begin
      testsFailed++;
      $display("[TB] FAIL collide_scoreboard: got %0d reads %0d writes expected 2 reads 1 write",
               rdObsQ.size(), wrObsQ.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    wrObsQ.delete(); rdObsQ.delete();
    issueAw(32'h80, 8'd3, ok);
    for (int k = 0; k < 2; k++) begin
      expMem[32+k] = 32'hAB00_0000 + 32'(k);
      sendBeat(32'hAB00_0000 + 32'(k), 4'hF, 1'b0, ok);
    end
    io_wData = 32'hAB00_0002; io_wStrb = 4'hF; io_wValid = 1'b1;
    reset = 1'b0;
    #1;
    testsRun++;
    if ({io_wReady, io_sram_en, io_sram_wen, io_bValid, io_rValid, io_arReady, io_awReady} !== 10'b0) begin
      testsFailed++; $display("[TB] FAIL midburst_outputs: got %b expected 0",
               {io_wReady, io_sram_en, io_sram_wen, io_bValid, io_rValid, io_arReady, io_awReady});
    end
    stepCycle();
    stepCycle();
    io_wValid = 1'b0;
    testsRun++;
    if (wrObsQ.size() != 2 || sramMem[34] !== expMem[34]) begin
      testsFailed++; $display("[TB] FAIL midburst_writes: got %0d writes word34=%h expected 2 and %h",
               wrObsQ.size(), sramMem[34], expMem[34]);
    end
    reset = 1'b1;
    stepCycle();
    issueAr(32'h80, 8'd0, ok);
    finishRead(ok);
    io_rReady = 1'b0;
    testsRun++;
    if (!ok || rdObsQ.size() != 1 || rdObsQ[0] !== {expMem[32], AXI_RESP_OKAY, 1'b1}) begin
      testsFailed++; $display("[TB] FAIL midburst_nextread: got %0d beats expected 1 of %h", rdObsQ.size(), expMem[32]);
    end
  endtask

`ifdef AXI_SRAM_RANGE_CHECK_EN
  task automatic test_range_check();
    bit ok;
    int enSnap;
    rdObsQ.delete(); wrObsQ.delete();
    enSnap = readEnCount;
    issueAr(32'h1000, 8'd0, ok);
    finishRead(ok);
    io_rReady = 1'b0;
    testsRun++;
    if (!ok || rdObsQ.size() != 1 || rdObsQ[0] !== {32'h0, AXI_RESP_SLVERR, 1'b1} || readEnCount != enSnap) begin
      testsFailed++; $display("[TB] FAIL range_read: got %0d beats reads=%0d expected SLVERR beat and no sram_en",
               rdObsQ.size(), readEnCount - enSnap);
    end
    issueAw(32'h1000, 8'd0, ok);
    sendBeat(32'h1234_5678, 4'hF, 1'b1, ok);
    @(negedge clock);
    testsRun++;
    if ({io_bValid, io_bResp} !== {1'b1, AXI_RESP_SLVERR} || wrObsQ.size() != 0) begin
      testsFailed++; $display("[TB] FAIL range_write: got bValid=%b bResp=%b writes=%0d expected 1/10/0",
               io_bValid, io_bResp, wrObsQ.size());
    end
    stepCycle();
    finishWrite(ok);
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << DEPTH_LOG2); i++) begin
      sramMem[i] = 32'hC0DE_0000 | 32'(i);
      expMem[i]  = 32'hC0DE_0000 | 32'(i);
    end
    test_reset();
    test_single_read();
    test_write_burst();
    test_back_to_back();
    test_backpressure();
    test_collision();
    test_reset_mid_burst();
`ifdef AXI_SRAM_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
